// File: rtl/alarm_trigger_ctrl.sv
// alarm_trigger_ctrl: decides when the alarm rings from the latched alarm time and the
// running clock. Provides arm/disarm, a timed ring window, a snooze with BCD time arithmetic,
// and a beeping buzzer output.
//
// Parameters
//   SNOOZE_MIN  snooze length in minutes (1..9)
//   RING_SEC    ring duration in tick_1hz pulses before automatic stop (2..255)
//   TONE_DIV    system clocks per buzzer half-period
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   tick_1hz    one-cycle pulse once per second
//   clock_time  current time, BCD {Ht,Ho,Mt,Mo,St,So}
//   alarm_time  programmed alarm time, same format
//   alarm_en    level: 1 arms, 0 disarms
//   snooze      single-cycle snooze request
//   stop        single-cycle stop request
//   alarm_out   high while ringing (registered)
//   buzzer      gated tone while ringing (registered)
//   snoozing    high while snoozing (registered)
//   state       00 disabled, 01 armed, 10 ringing, 11 snooze
module alarm_trigger_ctrl #(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned TONE_DIV   = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic [23:0] clock_time,
  input  logic [23:0] alarm_time,
  input  logic        alarm_en,
  input  logic        snooze,
  input  logic        stop,
  output logic        alarm_out,
  output logic        buzzer,
  output logic        snoozing,
  output logic [1:0]  state
);

  localparam int unsigned ToneW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  typedef enum logic [1:0] {
    StDisabled = 2'b00,
    StArmed    = 2'b01,
    StRinging  = 2'b10,
    StSnooze   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             match, match_q, hit;
  logic [7:0]       ring_cnt_q, ring_cnt_d;
  logic [ToneW-1:0] tone_cnt_q, tone_cnt_d;
  logic             tone_q, tone_d;
  logic [23:0]      snz_target_q, snz_target_d, snz_calc;
  logic [23:0]      target;
  logic             alarm_out_q, buzzer_q, snoozing_q;

  // Compare target follows the snooze time only while snoozing.
  assign target = (state_q == StSnooze) ? snz_target_q : alarm_time;
  assign match  = (clock_time == target);
  // Rising edge only: a time that stays equal never retriggers.
  assign hit    = match & ~match_q;

  // clock_time + SNOOZE_MIN minutes in BCD; seconds pass through.
  logic [4:0] mo_sum;
  logic [3:0] mo_new, mt_new, ho_new, ht_new;
  logic       mo_carry, hr_carry;

  always_comb begin
    mo_sum   = {1'b0, clock_time[11:8]} + 5'(SNOOZE_MIN);
    mo_new   = mo_sum[3:0];
    mo_carry = 1'b0;
    if (mo_sum > 5'd9) begin
      mo_new   = 4'(mo_sum - 5'd10);
      mo_carry = 1'b1;
    end

    mt_new   = clock_time[15:12];
    hr_carry = 1'b0;
    if (mo_carry) begin
      if (clock_time[15:12] == 4'd5) begin
        mt_new   = 4'd0;
        hr_carry = 1'b1;
      end else begin
        mt_new = clock_time[15:12] + 4'd1;
      end
    end

    ht_new = clock_time[23:20];
    ho_new = clock_time[19:16];
    if (hr_carry) begin
      if (clock_time[23:16] == 8'h23) begin
        ht_new = 4'd0;
        ho_new = 4'd0;
      end else if (clock_time[19:16] == 4'd9) begin
        ht_new = clock_time[23:20] + 4'd1;
        ho_new = 4'd0;
      end else begin
        ho_new = clock_time[19:16] + 4'd1;
      end
    end

    snz_calc = {ht_new, ho_new, mt_new, mo_new, clock_time[7:0]};
  end

  // Next-state logic; disarm overrides everything.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_target_d = snz_target_q;

    if (!alarm_en) begin
      state_d = StDisabled;
    end else begin
      case (state_q)
        StDisabled: state_d = StArmed;
        StArmed: begin
          if (hit) begin
            state_d    = StRinging;
            ring_cnt_d = 8'd0;
          end
        end
        StRinging: begin
          if (stop) begin
            state_d = StArmed;
          end else if (snooze) begin
            state_d      = StSnooze;
            snz_target_d = snz_calc;
          end else if (tick_1hz) begin
            if (ring_cnt_q == 8'(RING_SEC - 1)) begin
              state_d = StArmed;
            end else begin
              ring_cnt_d = ring_cnt_q + 8'd1;
            end
          end
        end
        StSnooze: begin
          if (stop) begin
            state_d = StArmed;
          end else if (hit) begin
            state_d    = StRinging;
            ring_cnt_d = 8'd0;
          end
        end
        default: state_d = StDisabled;
      endcase
    end
  end

  // Tone divider runs only while staying in RINGING, so each entry starts from zero.
  always_comb begin
    tone_cnt_d = '0;
    tone_d     = 1'b0;
    if (state_q == StRinging && state_d == StRinging) begin
      tone_d = tone_q;
      if (tone_cnt_q == ToneW'(TONE_DIV - 1)) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + ToneW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StDisabled;
      match_q      <= 1'b0;
      ring_cnt_q   <= 8'd0;
      tone_cnt_q   <= '0;
      tone_q       <= 1'b0;
      snz_target_q <= 24'd0;
      alarm_out_q  <= 1'b0;
      buzzer_q     <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match;
      ring_cnt_q   <= ring_cnt_d;
      tone_cnt_q   <= tone_cnt_d;
      tone_q       <= tone_d;
      snz_target_q <= snz_target_d;
      // Outputs registered from next-state values so they change with the state.
      alarm_out_q  <= (state_d == StRinging);
      snoozing_q   <= (state_d == StSnooze);
      // Odd seconds of the ring window mute the tone: 1 s on / 1 s off.
      buzzer_q     <= tone_d & ~ring_cnt_d[0];
    end
  end

  assign alarm_out = alarm_out_q;
  assign buzzer    = buzzer_q;
  assign snoozing  = snoozing_q;
  assign state     = state_q;

endmodule

// File: doc/alarm_trigger_ctrl.md
# alarm_trigger_ctrl

Consumer side of the alarm-time path: takes the latched `alarm_time` and the running `clock_time` and decides when the alarm rings. It provides arm/disarm, a timed ring window, snooze with BCD time arithmetic, and a beeping buzzer output. It sits between the alarm-time latch, the total-time counter and the buzzer/LED drivers.

## Interface
- `SNOOZE_MIN`, default 5: snooze length in minutes; legal range 1..9.
- `RING_SEC`, default 60: ring duration in seconds before automatic stop; legal range 2..255.
- `TONE_DIV`, default 50000: system clocks per buzzer half-period.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle pulse, once per second, synchronous to `clk`.
- `clock_time`  in  24  current time, BCD `{Ht,Ho,Mt,Mo,St,So}` (4 bits per digit), 00:00:00..23:59:59.
- `alarm_time`  in  24  programmed alarm time, same format.
- `alarm_en`  in  1  level; 1 arms the alarm, 0 disarms it.
- `snooze`  in  1  debounced single-cycle pulse.
- `stop`  in  1  debounced single-cycle pulse.
- `alarm_out`  out  1  high while ringing (registered).
- `buzzer`  out  1  gated tone while ringing (registered).
- `snoozing`  out  1  high while in SNOOZE (registered).
- `state`  out  2  00 DISABLED, 01 ARMED, 10 RINGING, 11 SNOOZE.

## Operation
- Target is `snooze_target` in SNOOZE and `alarm_time` in every other state.
- `match` = (`clock_time` == target). This is a combinational compare over all 24 bits.
- `match_q` registers `match` every cycle in every state.
- `hit` = `match & ~match_q`. It is a rising edge only, so a held-equal time never retriggers.
- State transitions. Priority within a cycle runs top to bottom:
  - `alarm_en`=0 in any state: go to DISABLED.
  - DISABLED: `alarm_en`=1 goes to ARMED. Enabling while the times are already equal does not ring, because `match_q` is already 1.
  - ARMED: `hit` goes to RINGING and clears `ring_cnt`.
  - RINGING: `stop` goes to ARMED. Otherwise `snooze` goes to SNOOZE and latches `snooze_target`. Otherwise a `tick_1hz` with `ring_cnt`==RING_SEC-1 goes to ARMED (timeout). Otherwise each `tick_1hz` increments `ring_cnt`.
  - SNOOZE: `stop` goes to ARMED. `hit` goes to RINGING and clears `ring_cnt`. `snooze` is ignored.
- `snooze_target` is `clock_time` at the cycle of the snooze pulse, plus SNOOZE_MIN minutes:
  - Seconds are copied unchanged.
  - Mo + SNOOZE_MIN: if the result is >9, subtract 10 and carry into Mt.
  - Mt 5 + carry gives 0 and carries into the hours.
  - Hours increment in BCD: Ho 9 goes to 0 with Ht+1; 23 goes to 00.
  - Example: 23:58:20 + 5 gives 00:03:20.
- Tone:
  - `tone_cnt` counts 0..TONE_DIV-1 while RINGING. `tone` toggles at wrap.
  - Both are held at 0 outside RINGING.
- `buzzer` = `tone & ~ring_cnt[0]`, giving a 1 s on / 1 s off beep pattern.
- `alarm_out` = (state==RINGING). `snoozing` = (state==SNOOZE).

## Timing
- Reset values: state DISABLED; `alarm_out`, `buzzer`, `snoozing`, `match_q`, `ring_cnt`, `tone_cnt`, `tone` and `snooze_target` are all 0. Outputs go low immediately on `rst` assertion, including mid-ring.
- Trigger latency: `clock_time` first equals the target in cycle N, and `alarm_out` is high in N+1.
- `stop`, `snooze` and `alarm_en`=0 take effect on the next edge. Outputs are updated in the same cycle as the state.
- Buzzer: the first rising edge comes TONE_DIV cycles after entering RINGING, and `buzzer` starts low.
- Ring window: ringing lasts exactly RING_SEC `tick_1hz` pulses counted from entry. The pulse that ends it moves the state to ARMED on that edge.
- `stop` and `snooze` in the same cycle: `stop` wins. `stop` together with a timeout tick ends in ARMED either way.
- After a stop or timeout, `match_q` remains 1 while `clock_time` is still equal, so there is no retrigger. The next ring is a day later unless snoozed.
- Pulses on `stop` or `snooze` in DISABLED or ARMED are ignored.

## Test plan
- Reset: assert `rst` mid-sequence. `state`=00 and all outputs are 0 asynchronously. After release with `alarm_en`=1, `state`=01 on the next edge.
- Basic ring with TONE_DIV=4:
  - Set `alarm_time`=07:30:00 and step `clock_time` 07:29:59 to 07:30:00. `alarm_out`=1 one cycle later, and `buzzer` rises 4 cycles after entry.
  - Pulse `stop`. `alarm_out`=0 next cycle, with no retrigger while the clock holds 07:30:00.
- Timeout with RING_SEC=3: enter RINGING, then apply 3 `tick_1hz` pulses. `state` returns to 01 on the 3rd pulse, and `buzzer` is gated off during the odd second.
- Snooze wrap with SNOOZE_MIN=5:
  - Snooze at 23:58:20 gives `snoozing`=1 and target 00:03:20. RINGING resumes one cycle after `clock_time`=00:03:20.
  - Snooze at 09:57:10 gives target 10:02:10.
- Simultaneous events:
  - `stop` and `snooze` in the same cycle in RINGING gives ARMED.
  - `alarm_en`=0 during RINGING or SNOOZE gives `state`=00 and all outputs 0 next cycle.
- Enable while equal: `clock_time`=`alarm_time`=12:00:00, then raise `alarm_en`. There is no ring. Then step the clock 12:00:01 and back to 12:00:00. It rings.
